// File: rtl/data_mem_loader.sv
// Streams a length-prefixed big-endian word image into the MIPS data-memory init port, holding the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by `define DATA_LOADER_CHECKSUM_EN.
module data_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              data_init_write_enable,
  output logic [ADDR_W-1:0] data_init_addr,
  output logic [31:0]       data_init_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_BYTES = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef DATA_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] lenReg;
  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        byteCnt;
  logic [23:0]       partial;
  logic              take;
  logic              lastWord;
  logic              canStart;

  assign take     = in_valid && in_ready;
  // N=0 latches as 0, so N-1 wraps to the top index and covers the full 2^ADDR_W image.
  assign lastWord = (wordIdx == lenReg - ADDR_W'(1));

`ifdef DATA_LOADER_CHECKSUM_EN
  logic [7:0] xorAcc;

  assign in_ready = (state == S_LEN) || (state == S_BYTES) || (state == S_CSUM);
  assign error    = (state == S_ERROR);
  assign busy     = (state == S_LEN) || (state == S_BYTES) || (state == S_WRITE) || (state == S_CSUM);
`else
  assign in_ready = (state == S_LEN) || (state == S_BYTES);
  assign error    = 1'b0;
  assign busy     = (state == S_LEN) || (state == S_BYTES) || (state == S_WRITE);
`endif

  assign canStart               = (state == S_IDLE) || (state == S_DONE) || error;
  assign data_init_write_enable = (state == S_WRITE);
  assign done                   = (state == S_DONE);
  assign cpu_hold               = (state != S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      lenReg         <= '0;
      wordIdx        <= '0;
      byteCnt        <= '0;
      partial        <= '0;
      data_init_addr <= '0;
      data_init_data <= '0;
`ifdef DATA_LOADER_CHECKSUM_EN
      xorAcc         <= '0;
`endif
    end else if (canStart && start) begin
      state   <= S_LEN;
      wordIdx <= '0;
      byteCnt <= '0;
`ifdef DATA_LOADER_CHECKSUM_EN
      xorAcc  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: ;
        S_LEN: begin
          if (take) begin
            lenReg <= ADDR_W'(in_data);
            state  <= S_BYTES;
          end
        end
        S_BYTES: begin
          if (take) begin
            partial <= {partial[15:0], in_data};
            byteCnt <= byteCnt + 2'd1;
`ifdef DATA_LOADER_CHECKSUM_EN
            xorAcc  <= xorAcc ^ in_data;
`endif
            // Output registers only load here so addr/data stay stable outside WRITE.
            if (byteCnt == 2'd3) begin
              data_init_data <= {partial, in_data};
              data_init_addr <= wordIdx;
              state          <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (lastWord) begin
`ifdef DATA_LOADER_CHECKSUM_EN
            state <= S_CSUM;
`else
            state <= S_DONE;
`endif
          end else begin
            wordIdx <= wordIdx + ADDR_W'(1);
            state   <= S_BYTES;
          end
        end
`ifdef DATA_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (take) state <= (in_data == xorAcc) ? S_DONE : S_ERROR;
        end
        S_ERROR: ;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_loader.sv
// Directed bench for data_mem_loader: reset, two-word load, stall, checksum fail, N=0 wrap, reset mid-word.
module tb_data_mem_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, data_init_write_enable, cpu_hold, busy, done, error;
  logic [7:0]  data_init_addr;
  logic [31:0] data_init_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          startCyc;
  logic [7:0]  tbXor;
  logic [7:0]  wAddr[$];
  logic [31:0] wData[$];
  int          wCyc[$];

  data_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_init_write_enable(data_init_write_enable),
    .data_init_addr(data_init_addr), .data_init_data(data_init_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_init_write_enable) begin
      wAddr.push_back(data_init_addr);
      wData.push_back(data_init_data);
      wCyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    wAddr.delete();
    wData.delete();
    wCyc.delete();
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    startCyc = cyc;
    tbXor = 8'h00;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) begin
      sendByte(w[k*8 +: 8]);
      tbXor = tbXor ^ w[k*8 +: 8];
    end
  endtask

  task automatic sendCsum();
`ifdef DATA_LOADER_CHECKSUM_EN
    sendByte(tbXor);
`endif
  endtask

  task automatic twoWord(input bit stall, input string pfx);
    clearLog();
    startPulse();
    sendByte(8'h02);
    sendByte(8'h12);
    sendByte(8'h34);
    tbXor = 8'h12 ^ 8'h34;
    if (stall) waitCycles(7);
    sendByte(8'h56);
    sendByte(8'h78);
    tbXor = tbXor ^ 8'h56 ^ 8'h78;
    sendWord(32'hDEADBEEF);
    sendCsum();
    waitCycles(3);
    check({pfx, "_nwrites"}, wAddr.size(), 2);
    if (wAddr.size() == 2) begin
      check({pfx, "_addr0"}, wAddr[0], 0);
      check({pfx, "_data0"}, wData[0], 32'h12345678);
      check({pfx, "_addr1"}, wAddr[1], 1);
      check({pfx, "_data1"}, wData[1], 32'hDEADBEEF);
      check({pfx, "_lat0"}, wCyc[0] - startCyc, stall ? 12 : 5);
      check({pfx, "_gap"}, wCyc[1] - wCyc[0], 5);
    end
    check({pfx, "_done"}, done, 1);
    check({pfx, "_hold"}, cpu_hold, 0);
    check({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; tbXor = 8'h00; startCyc = 0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(5);
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_we", data_init_write_enable, 0);
    check("rst_addr", data_init_addr, 0);
    check("rst_data", data_init_data, 0);
    check("rst_nwrites", wAddr.size(), 0);

    twoWord(1'b0, "plain");
    twoWord(1'b1, "stall");

`ifdef DATA_LOADER_CHECKSUM_EN
    clearLog();
    startPulse();
    sendByte(8'h01);
    sendWord(32'h00000001);
    sendByte(8'h00);
    waitCycles(2);
    check("cs_nwrites", wAddr.size(), 1);
    if (wAddr.size() == 1) check("cs_data0", wData[0], 32'h00000001);
    check("cs_error", error, 1);
    check("cs_hold", cpu_hold, 1);
    check("cs_done", done, 0);
    startPulse();
    check("cs_restart_error", error, 0);
    check("cs_restart_busy", busy, 1);
    sendByte(8'h01);
    sendWord(32'h00000005);
    sendCsum();
    waitCycles(2);
    check("cs_recover_done", done, 1);
`endif

    clearLog();
    startPulse();
    sendByte(8'h00);
    for (int i = 0; i < 256; i++) sendWord(32'(i));
    sendCsum();
    waitCycles(3);
    check("wrap_nwrites", wAddr.size(), 256);
    for (int i = 0; i < wAddr.size() && i < 256; i++) begin
      check("wrap_addr", wAddr[i], 32'(i));
      check("wrap_data", wData[i], 32'(i));
    end
    check("wrap_done", done, 1);
    check("wrap_hold", cpu_hold, 0);

    clearLog();
    startPulse();
    sendByte(8'h02);
    sendWord(32'hA5A5A5A5);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    check("mrst_we", data_init_write_enable, 0);
    waitCycles(3);
    check("mrst_nwrites", wAddr.size(), 1);
    check("mrst_busy", busy, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_hold", cpu_hold, 1);
    clearLog();
    startPulse();
    sendByte(8'h01);
    sendWord(32'hCAFEF00D);
    sendCsum();
    waitCycles(3);
    check("mrst_re_nwrites", wAddr.size(), 1);
    if (wAddr.size() == 1) begin
      check("mrst_re_addr", wAddr[0], 0);
      check("mrst_re_data", wData[0], 32'hCAFEF00D);
    end
    check("mrst_re_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
